fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single write port of custom_async_fifo among NUM_REQ producers.
//  Sits entirely in the FIFO write-clock domain.
//  Grants bounded bursts, honours full/almost-full back-pressure without overflow, and drives registered wen/din.
// PARAMETERS
//  DATASIZE   8  width of one data word (matches FIFO DATASIZE)
//  NUM_REQ    4  number of requesters, >=2
//  MAX_BURST  4  max consecutive beats per grant before rotation, >=1
// PORTS
//  clk_i               in   1                  write clock (same net as FIFO wclk_i)
//  rst_n_i             in   1                  async active-low reset
//  enable_i            in   1                  0 = issue no new beats
//  req_mask_i          in   NUM_REQ            1 = requester eligible
//  req_valid_i         in   NUM_REQ            requester i has a word
//  req_data_i          in   NUM_REQ*DATASIZE   word i at [i*DATASIZE +: DATASIZE]
//  req_ready_o         out  NUM_REQ            one-hot-or-zero accept
//  fifo_full_i         in   1                  FIFO fifo_full
//  fifo_almost_full_i  in   1                  FIFO fifo_almost_full (<=1 free slot)
//  wen_o               out  1                  FIFO wen
//  din_o               out  DATASIZE           FIFO din
//  src_id_o            out  $clog2(NUM_REQ)    requester index of the word on din_o
//  busy_o              out  1                  state != IDLE
// BEHAVIOUR
//  Reset (async, immediate): wen_o=0, din_o=0, src_id_o=0, state=IDLE, rr_ptr=0, beat_cnt=0.
//  During reset, req_ready_o=0.
//  Handshake: a beat transfers on req_valid_i[i] && req_ready_o[i]; ready never depends on ready.
//  Latency: a beat accepted in cycle t appears as wen_o=1, din_o=word, src_id_o=i in cycle t+1.
//  wen_o is otherwise 0; din_o and src_id_o hold their last values.
//  space = !fifo_full_i && !(wen_o && fifo_almost_full_i).
//  This guards the one-cycle registered write in flight, so the FIFO never sees wen while full.
//  eligible[i] = enable_i && req_mask_i[i] && req_valid_i[i].
//  FSM states:
//   IDLE:  if space && |eligible, pick the first eligible index at or after rr_ptr (wrapping).
//          Assert its ready in the same cycle, owner=winner, beat_cnt=1.
//          Go to BURST if MAX_BURST>1, else stay in IDLE with rr_ptr=winner+1 mod NUM_REQ.
//   BURST: ready[owner] = space && eligible[owner].
//          On a beat: beat_cnt++; at MAX_BURST go to IDLE with rr_ptr=owner+1.
//          If !eligible[owner] (valid drop, mask clear, or enable low): go to IDLE with rr_ptr=owner+1, no beat.
//          If eligible[owner] && !space: go to HOLD.
//   HOLD:  all ready=0; owner and beat_cnt are kept.
//          Go to BURST when space; go to IDLE with rr_ptr=owner+1 if !eligible[owner].
//  A requester dropping valid ends its burst; the beat count is not refunded.
//  Wrap: rr_ptr and the search wrap modulo NUM_REQ. NUM_REQ need not be a power of 2.
//  Simultaneous requests always resolve by round-robin order, never by index.
//  Fairness bound: any requester that is continuously eligible is granted within (NUM_REQ-1)*MAX_BURST beats.
//  Overflow-free: at most one write is in flight, and no grant is made when space=0.
// STRUCTURE
//  fifo_arb_pkg: typedef enum logic [1:0] {ARB_IDLE, ARB_BURST, ARB_HOLD} arb_state_t.
//  fifo_arb_pkg also holds the function for index width ($clog2 helper, with NUM_REQ=1 guarded).
//  Sub-module rr_pick: combinational, given eligible vector + ptr, returns found + index.
//  Top module holds the FSM, rr_ptr, owner, beat_cnt and the output registers.
// TESTING (bench instantiates fifo_wr_arbiter + custom_async_fifo, DEPTH=4 i.e. 16 entries)
//  1 Reset: rst_n_i low mid-burst -> same cycle wen_o=0, busy_o=0, all ready=0.
//    After release, first grant goes to req 0.
//  2 All 4 valid continuously, MAX_BURST=4 -> src_id_o sequence 0,0,0,0,1,1,1,1,2,...,3,0.
//    No gaps while the FIFO has space.
//  3 Reader stopped, req 1 streams 0x01.. -> exactly 16 writes accepted, FIFO full, wen_o never high while full.
//    State HOLD, ready=0.
//  4 From test 3, reader pops 1 word -> exactly one more beat is written.
//    Burst resumes from the held beat_cnt.
//  5 Req 2 drops valid after 2 beats while req 3 valid -> next beat has src_id_o=3, rr_ptr=3.
//  6 req_mask_i=4'b1010, all valid -> only ids 1,3 alternate.
//    enable_i=0 -> zero wen_o from the second cycle after deassertion.
//  Reader side: scoreboard checks per-source order and data integrity through the async FIFO.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_HOLD  = 2'd2
    } arb_state_t;

    // Width of an index into n items; a single item still needs one bit.
    function automatic int idx_width(input int n);
        int w;
        if (n <= 1) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first eligible index at or after ptr, wrapping modulo NUM_REQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDXW-1:0]    ptr,
    output logic               found,
    output logic [IDXW-1:0]    idx
);

    localparam int SW = IDXW + 1;

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [SW-1:0]        sum_s;
    logic                 hit_s;

    // Rotate the request vector so bit 0 is the pointer, then take the lowest set bit.
    always_comb begin
        found = 1'b0;
        idx   = {IDXW{1'b0}};
        sum_s = {SW{1'b0}};
        hit_s = 1'b0;
        dbl_s = {eligible, eligible} >> ptr;
        rot_s = dbl_s[NUM_REQ-1:0];
        for (int k = 0; k < NUM_REQ; k++) begin
            hit_s = !found && rot_s[k];
            sum_s = {1'b0, ptr} + SW'(k);
            sum_s = (sum_s >= SW'(NUM_REQ)) ? (sum_s - SW'(NUM_REQ)) : sum_s;
            idx   = hit_s ? IDXW'(sum_s) : idx;
            found = found | hit_s;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Beats accepted in one cycle appear on the registered wen/din/src_id the next cycle.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATASIZE  = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          enable_i,
    input  logic [NUM_REQ-1:0]            req_mask_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATASIZE-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    input  logic                          fifo_almost_full_i,
    output logic                          wen_o,
    output logic [DATASIZE-1:0]           din_o,
    output logic [idx_width(NUM_REQ)-1:0] src_id_o,
    output logic                          busy_o
);

    localparam int              IDXW     = idx_width(NUM_REQ);
    localparam int              CNTW     = idx_width(MAX_BURST + 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REQ - 1);
    localparam logic [CNTW-1:0] MAX_CNT  = CNTW'(MAX_BURST);

    arb_state_t           state_r;
    logic [IDXW-1:0]      rr_ptr_r;
    logic [IDXW-1:0]      owner_r;
    logic [CNTW-1:0]      beat_cnt_r;
    logic                 wen_r;
    logic [DATASIZE-1:0]  din_r;
    logic [IDXW-1:0]      src_id_r;

    logic                 space_s;
    logic [NUM_REQ-1:0]   eligible_s;
    logic                 found_s;
    logic [IDXW-1:0]      win_s;
    logic                 owner_elig_s;
    logic [NUM_REQ-1:0]   ready_s;
    logic                 beat_s;
    logic [IDXW-1:0]      beat_id_s;
    logic [DATASIZE-1:0]  beat_data_s;

    // Successor index modulo NUM_REQ (NUM_REQ need not be a power of two).
    function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
        return (i == LAST_IDX) ? {IDXW{1'b0}} : (i + IDXW'(1));
    endfunction

    // The registered write in flight counts against the last free slot.
    assign space_s      = !fifo_full_i && !(wen_r && fifo_almost_full_i);
    assign eligible_s   = {NUM_REQ{enable_i}} & req_mask_i & req_valid_i;
    assign owner_elig_s = eligible_s[owner_r];

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_rr_pick (
        .eligible (eligible_s),
        .ptr      (rr_ptr_r),
        .found    (found_s),
        .idx      (win_s)
    );

    // Grant decision: only state, eligibility and space feed ready, never ready itself.
    always_comb begin
        ready_s = {NUM_REQ{1'b0}};
        case (state_r)
            ARB_IDLE: begin
                if (space_s && found_s) begin
                    ready_s[win_s] = 1'b1;
                end else begin
                    ready_s = {NUM_REQ{1'b0}};
                end
            end
            ARB_BURST: begin
                if (space_s && owner_elig_s) begin
                    ready_s[owner_r] = 1'b1;
                end else begin
                    ready_s = {NUM_REQ{1'b0}};
                end
            end
            default: ready_s = {NUM_REQ{1'b0}};
        endcase
    end

    assign beat_s    = |ready_s;
    assign beat_id_s = (state_r == ARB_IDLE) ? win_s : owner_r;

    // Select the accepted requester's data word.
    always_comb begin
        beat_data_s = {DATASIZE{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            beat_data_s = (beat_id_s == IDXW'(i)) ? req_data_i[i*DATASIZE +: DATASIZE] : beat_data_s;
        end
    end

    // Arbitration FSM plus the registered FIFO write interface.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r    <= ARB_IDLE;
            rr_ptr_r   <= {IDXW{1'b0}};
            owner_r    <= {IDXW{1'b0}};
            beat_cnt_r <= {CNTW{1'b0}};
            wen_r      <= 1'b0;
            din_r      <= {DATASIZE{1'b0}};
            src_id_r   <= {IDXW{1'b0}};
        end else begin
            wen_r <= beat_s;
            if (beat_s) begin
                din_r    <= beat_data_s;
                src_id_r <= beat_id_s;
            end
            case (state_r)
                ARB_IDLE: begin
                    if (beat_s) begin
                        owner_r    <= win_s;
                        beat_cnt_r <= CNTW'(1);
                        if (MAX_BURST > 1) begin
                            state_r <= ARB_BURST;
                        end else begin
                            rr_ptr_r <= next_idx(win_s);
                        end
                    end
                end
                ARB_BURST: begin
                    if (beat_s) begin
                        beat_cnt_r <= beat_cnt_r + CNTW'(1);
                        if ((beat_cnt_r + CNTW'(1)) == MAX_CNT) begin
                            state_r  <= ARB_IDLE;
                            rr_ptr_r <= next_idx(owner_r);
                        end
                    end else if (!owner_elig_s) begin
                        state_r  <= ARB_IDLE;
                        rr_ptr_r <= next_idx(owner_r);
                    end else begin
                        state_r <= ARB_HOLD;
                    end
                end
                ARB_HOLD: begin
                    if (!owner_elig_s) begin
                        state_r  <= ARB_IDLE;
                        rr_ptr_r <= next_idx(owner_r);
                    end else if (space_s) begin
                        state_r <= ARB_BURST;
                    end
                end
                default: state_r <= ARB_IDLE;
            endcase
        end
    end

    assign req_ready_o = ready_s & {NUM_REQ{rst_n_i}};
    assign wen_o       = wen_r;
    assign din_o       = din_r;
    assign src_id_o    = src_id_r;
    assign busy_o      = (state_r != ARB_IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a 16-entry FIFO model on the write clock, a behavioural
// arbiter model compared every cycle, a reader-side scoreboard and directed scenarios.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int MB = 4;
    localparam int FDEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  mask = 4'h0;
    logic [3:0]  valid = 4'h0;
    logic [31:0] data;
    logic [3:0]  ready;
    logic        full, afull;
    logic        wen;
    logic [7:0]  din;
    logic [1:0]  src;
    logic        busy;
    logic        rd_en = 1'b0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DATASIZE(8), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .enable_i           (enable),
        .req_mask_i         (mask),
        .req_valid_i        (valid),
        .req_data_i         (data),
        .req_ready_o        (ready),
        .fifo_full_i        (full),
        .fifo_almost_full_i (afull),
        .wen_o              (wen),
        .din_o              (din),
        .src_id_o           (src),
        .busy_o             (busy)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Producers: word = {id, sequence}; sequence advances on each handshake.
    logic [5:0] seq [4] = '{default: 6'd0};
    assign data = {2'd3, seq[3], 2'd2, seq[2], 2'd1, seq[1], 2'd0, seq[0]};

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (ready[i] && valid[i]) seq[i] <= seq[i] + 6'd1;
        end
    end

    // FIFO model, write log and reader scoreboard.
    logic [9:0] fq [$];
    int         fcount = 0;
    logic [1:0] wr_log [$];
    int         wr_cyc [$];
    int         cyc = 0;
    int         last_seq [4] = '{default: -1};
    assign full  = (fcount >= FDEPTH);
    assign afull = (fcount >= FDEPTH - 1);

    always @(posedge clk) begin : fifo_side
        logic [9:0] ent;
        if (rd_en && fq.size() > 0) begin
            ent = fq.pop_front();
            check("sb_src_tag", {30'd0, ent[7:6]}, {30'd0, ent[9:8]});
            check("sb_order", (int'(ent[5:0]) > last_seq[ent[9:8]]) ? 32'd1 : 32'd0, 32'd1);
            last_seq[ent[9:8]] = int'(ent[5:0]);
        end
        if (wen) begin
            check("wen_while_full", {31'd0, full}, 32'd0);
            fq.push_back({src, din});
            wr_log.push_back(src);
            wr_cyc.push_back(cyc);
        end
        fcount <= fq.size();
        cyc = cyc + 1;
    end

    // Behavioural arbiter model: owner (-1 = none), beats used, pointer, stalled flag.
    int         m_owner = -1, m_cnt = 0, m_ptr = 0;
    bit         m_stall = 1'b0, m_wen = 1'b0;
    logic [7:0] m_din = 8'h00;
    logic [1:0] m_src = 2'd0;
    int         d_acc = -1;
    bit         d_space = 1'b0;
    logic [3:0] d_elig = 4'h0;
    logic [7:0] d_data = 8'h00;

    task automatic model_reset();
        m_owner = -1; m_cnt = 0; m_ptr = 0; m_stall = 1'b0;
        m_wen = 1'b0; m_din = 8'h00; m_src = 2'd0;
    endtask

    task automatic release_owner();
        m_ptr = (m_owner + 1) % NR; m_owner = -1; m_cnt = 0; m_stall = 1'b0;
    endtask

    // Compare process: decide this cycle's expected grant and check all outputs.
    always @(negedge clk) begin : compare
        logic [3:0] exp_ready;
        int sel;
        if (!rst_n) model_reset();
        d_elig  = {4{enable}} & mask & valid;
        d_space = !full && !(m_wen && afull);
        d_acc   = -1;
        if (rst_n) begin
            if (m_owner < 0) begin
                for (int k = 0; k < NR; k++) begin
                    sel = (m_ptr + k) % NR;
                    if (d_acc < 0 && d_elig[sel[1:0]]) d_acc = sel;
                end
                if (!d_space) d_acc = -1;
            end else if (!m_stall && d_space && d_elig[m_owner[1:0]]) begin
                d_acc = m_owner;
            end
        end
        exp_ready = (d_acc >= 0) ? (4'b0001 << d_acc) : 4'b0000;
        d_data    = (d_acc >= 0) ? 8'(data >> (8 * d_acc)) : 8'h00;
        check("ready", {28'd0, ready}, {28'd0, exp_ready});
        check("wen", {31'd0, wen}, {31'd0, m_wen});
        check("din", {24'd0, din}, {24'd0, m_din});
        check("src_id", {30'd0, src}, {30'd0, m_src});
        check("busy", {31'd0, busy}, (m_owner >= 0) ? 32'd1 : 32'd0);
    end

    // Model state update at the clock edge from the decision made above.
    always @(posedge clk) begin : model_step
        if (!rst_n) begin
            model_reset();
        end else begin
            m_wen = (d_acc >= 0);
            if (d_acc >= 0) begin
                m_din = d_data;
                m_src = 2'(d_acc);
            end
            if (m_owner < 0) begin
                if (d_acc >= 0) begin
                    if (MB > 1) begin
                        m_owner = d_acc; m_cnt = 1; m_stall = 1'b0;
                    end else begin
                        m_ptr = (d_acc + 1) % NR;
                    end
                end
            end else if (m_stall) begin
                if (!d_elig[m_owner[1:0]]) release_owner();
                else if (d_space) m_stall = 1'b0;
            end else if (d_acc >= 0) begin
                m_cnt++;
                if (m_cnt == MB) release_owner();
            end else if (!d_elig[m_owner[1:0]]) begin
                release_owner();
            end else begin
                m_stall = 1'b1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_log(input int n, input int budget, input string nm);
        int b = 0;
        while (wr_log.size() < n && b < budget) begin
            step(1);
            b++;
        end
        check(nm, (wr_log.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_seq(input int i, input logic [5:0] target, input int budget, input string nm);
        int b = 0;
        while (seq[i] != target && b < budget) begin
            step(1);
            b++;
        end
        check(nm, {26'd0, seq[i]}, {26'd0, target});
    endtask

    int         exp_rr [17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
    int         exp_mask [9] = '{1,1,1,1,3,3,3,3,1};
    logic [5:0] base;

    initial begin
        step(3);
        rst_n = 1'b1; mask = 4'hF; enable = 1'b1; valid = 4'hF; rd_en = 1'b1;

        // 1: reset mid-burst clears outputs immediately
        wait_log(2, 20, "t1_start");
        check("t1_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t1_wen_rst", {31'd0, wen}, 32'd0);
        check("t1_busy_rst", {31'd0, busy}, 32'd0);
        check("t1_ready_rst", {28'd0, ready}, 32'd0);
        step(2);
        rst_n = 1'b1;
        wr_log.delete(); wr_cyc.delete();

        // 2: all requesting, bursts of four in rotation with no gaps
        wait_log(17, 40, "t2_wait");
        if (wr_log.size() >= 17) begin
            for (int i = 0; i < 17; i++) check("t2_rr_seq", {30'd0, wr_log[i]}, exp_rr[i]);
            check("t2_nogap", wr_cyc[16] - wr_cyc[0], 32'd16);
        end

        // 3: reader stopped, FIFO fills to exactly 16, arbiter holds mid-burst
        valid = 4'h0;
        step(25);
        rd_en = 1'b0;
        wr_log.delete();
        valid = 4'b0001;
        base = seq[0];
        wait_seq(0, base + 6'd2, 20, "t3_req0_two");
        valid = 4'b0000;
        step(5);
        valid = 4'b0010;
        step(40);
        check("t3_writes", wr_log.size(), 32'd16);
        check("t3_full", {31'd0, full}, 32'd1);
        check("t3_ready", {28'd0, ready}, 32'd0);
        check("t3_busy", {31'd0, busy}, 32'd1);

        // 4: each pop admits exactly one beat; the held count then ends the burst
        rd_en = 1'b1; step(1); rd_en = 1'b0;
        step(8);
        check("t4_one_more", wr_log.size(), 32'd17);
        check("t4_busy", {31'd0, busy}, 32'd1);
        check("t4_full", {31'd0, full}, 32'd1);
        rd_en = 1'b1; step(1); rd_en = 1'b0;
        step(8);
        check("t4_second", wr_log.size(), 32'd18);
        check("t4_burst_end", {31'd0, busy}, 32'd0);
        if (wr_log.size() >= 18) check("t4_src", {30'd0, wr_log[17]}, 32'd1);

        // 5: owner drops valid after two beats, next beat goes to req 3
        valid = 4'h0; rd_en = 1'b1;
        step(25);
        wr_log.delete();
        valid = 4'b1100;
        base = seq[2];
        wait_seq(2, base + 6'd2, 20, "t5_req2_two");
        valid = 4'b1000;
        step(10);
        check("t5_count", (wr_log.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
        if (wr_log.size() >= 3) begin
            check("t5_first", {30'd0, wr_log[0]}, 32'd2);
            check("t5_second", {30'd0, wr_log[1]}, 32'd2);
            check("t5_handover", {30'd0, wr_log[2]}, 32'd3);
        end

        // 6: mask 1010 alternates ids 1 and 3; disabling stops writes
        valid = 4'h0;
        step(10);
        wr_log.delete();
        mask = 4'b1010; valid = 4'hF;
        wait_log(9, 30, "t6_wait");
        if (wr_log.size() >= 9) begin
            for (int i = 0; i < 9; i++) check("t6_mask_seq", {30'd0, wr_log[i]}, exp_mask[i]);
        end
        enable = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t6_disable_wen", {31'd0, wen}, 32'd0);
        end
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
